// File: rtl/sweep_avg_pkg.sv
// Shared types for the sweep result averager: FSM states, default sizes and the
// packed modulo/phase accumulator pair stored in the accumulator RAM.
package sweep_avg_pkg;

  localparam int NUM_POINTS_DEF = 200;
  localparam int ACC_WIDTH_DEF  = 40;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    READ,
    ACC,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [ACC_WIDTH_DEF-1:0] acc_m;
    logic signed [ACC_WIDTH_DEF-1:0] acc_p;
  } acc_pair_t;

endpackage

// File: rtl/sweep_result_averager_if.sv
// Result stream from the sweep controller plus the processor read port of the
// averaged-result RAM.
interface sweep_result_averager_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                         valid_m;
    logic signed [DATA_WIDTH-1:0] modulo;
    logic signed [DATA_WIDTH-1:0] phase;
    logic [ADDR_WIDTH-1:0]        index;
    logic                         rd_en;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_modulo;
    logic signed [DATA_WIDTH-1:0] rd_phase;
    logic                         rd_valid;

    modport master (
        output valid_m, modulo, phase, index, rd_en, rd_addr,
        input  rd_modulo, rd_phase, rd_valid
    );

    modport slave (
        input  valid_m, modulo, phase, index, rd_en, rd_addr,
        output rd_modulo, rd_phase, rd_valid
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module sdp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 200,
    parameter int AW    = 8
) (
    input  logic             clk125,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk125) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sweep_result_averager.sv
// Averages 2^avg_log2 sweeps of per-point modulo/phase results from the sweep
// controller and serves the averages to the processor through a registered port.
module sweep_result_averager
    import sweep_avg_pkg::*;
#(
    parameter int NUM_POINTS = NUM_POINTS_DEF,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                    clk125,
    input  logic                    areset_n,
    input  logic                    start,
    input  logic [2:0]              avg_log2,
    sweep_result_averager_if.slave  bus,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              sweep_count,
    output logic                    err_overrun,
    output logic                    err_index
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_POINTS - 1);

    if (ACC_WIDTH != $bits(acc_pair_t) / 2 || ACC_WIDTH < DATA_WIDTH + 7) begin : g_bad_cfg
        $error("ACC_WIDTH must match acc_pair_t and be at least DATA_WIDTH+7");
    end

    state_t                       state, state_nxt;
    logic [ADDR_WIDTH-1:0]        clr_addr;
    logic [2:0]                   shift_q;
    logic [7:0]                   target;
    logic signed [DATA_WIDTH-1:0] mod_p0, ph_p0;
    logic [ADDR_WIDTH-1:0]        idx_p0;
    acc_pair_t                    acc_rd, acc_wr;
    logic                         acc_we;
    logic [ADDR_WIDTH-1:0]        acc_waddr;
    logic signed [ACC_WIDTH-1:0]  sum_m, sum_p;
    logic                         res_we, rd_re, rd_zero;
    logic [2*DATA_WIDTH-1:0]      res_wdata, res_rd;
    logic                         sample_ok, final_pass, last_idx;

    // Arithmetic shift floors toward -inf; the low DATA_WIDTH bits are the average.
    function automatic logic signed [DATA_WIDTH-1:0] scale_avg(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic [2:0]                  sh
    );
        logic signed [ACC_WIDTH-1:0] shifted;
        shifted = acc >>> sh;
        return $signed(shifted[DATA_WIDTH-1:0]);
    endfunction

    assign target     = 8'd1 << shift_q;
    assign sample_ok  = (state == WAIT) && bus.valid_m && (bus.index <= LAST_IDX);
    assign final_pass = (sweep_count == target - 8'd1);
    assign last_idx   = (idx_p0 == LAST_IDX);
    assign sum_m      = acc_rd.acc_m + ACC_WIDTH'(mod_p0);
    assign sum_p      = acc_rd.acc_p + ACC_WIDTH'(ph_p0);
    assign res_wdata  = {scale_avg(sum_m, shift_q), scale_avg(sum_p, shift_q)};
    assign busy       = state inside {CLEAR, WAIT, READ, ACC};
    assign done       = (state == DONE);

    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Dropping start in any busy state returns to IDLE with no RAM write that cycle.
    always_comb begin
        state_nxt    = state;
        acc_we       = 1'b0;
        acc_waddr    = idx_p0;
        acc_wr.acc_m = sum_m;
        acc_wr.acc_p = sum_p;
        res_we       = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: begin
                if (!start) state_nxt = IDLE;
                else begin
                    acc_we    = 1'b1;
                    acc_waddr = clr_addr;
                    acc_wr    = '0;
                    if (clr_addr == LAST_IDX) state_nxt = WAIT;
                end
            end
            WAIT:  if (!start) state_nxt = IDLE; else if (sample_ok) state_nxt = READ;
            READ:  state_nxt = start ? ACC : IDLE;
            ACC: begin
                if (!start) state_nxt = IDLE;
                else begin
                    acc_we    = 1'b1;
                    res_we    = final_pass;
                    state_nxt = (last_idx && (sweep_count + 8'd1) == target) ? DONE : WAIT;
                end
            end
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd_zero comes out of reset set so the read outputs read 0 before any read.
    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            sweep_count  <= '0;
            err_overrun  <= 1'b0;
            err_index    <= 1'b0;
            clr_addr     <= '0;
            shift_q      <= '0;
            bus.rd_valid <= 1'b0;
            rd_zero      <= 1'b1;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) rd_zero <= (bus.rd_addr > LAST_IDX);
            if (state == IDLE) begin
                sweep_count <= '0;
                err_overrun <= 1'b0;
                err_index   <= 1'b0;
                clr_addr    <= '0;
                shift_q     <= avg_log2;
            end
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
            if ((state inside {CLEAR, READ, ACC}) && bus.valid_m) err_overrun <= 1'b1;
            if (state == WAIT && bus.valid_m && bus.index > LAST_IDX) err_index <= 1'b1;
            if (state == ACC && start && last_idx && sweep_count != 8'hFF)
                sweep_count <= sweep_count + 8'd1;
        end
    end

    always_ff @(posedge clk125) begin
        if (sample_ok) begin
            mod_p0 <= bus.modulo;
            ph_p0  <= bus.phase;
            idx_p0 <= bus.index;
        end
    end

    sdp_ram #(.WIDTH(2 * ACC_WIDTH), .DEPTH(NUM_POINTS), .AW(ADDR_WIDTH)) u_acc_ram (
        .clk125 (clk125),
        .we     (acc_we),
        .waddr  (acc_waddr),
        .wdata  (acc_wr),
        .re     (state == READ),
        .raddr  (idx_p0),
        .rdata  (acc_rd)
    );

    assign rd_re = bus.rd_en && (bus.rd_addr <= LAST_IDX);

    sdp_ram #(.WIDTH(2 * DATA_WIDTH), .DEPTH(NUM_POINTS), .AW(ADDR_WIDTH)) u_res_ram (
        .clk125 (clk125),
        .we     (res_we),
        .waddr  (idx_p0),
        .wdata  (res_wdata),
        .re     (rd_re),
        .raddr  (bus.rd_addr),
        .rdata  (res_rd)
    );

    assign bus.rd_modulo = rd_zero ? '0 : $signed(res_rd[2*DATA_WIDTH-1:DATA_WIDTH]);
    assign bus.rd_phase  = rd_zero ? '0 : $signed(res_rd[DATA_WIDTH-1:0]);
endmodule

// File: tb/tb_sweep_result_averager.sv
// Scoreboard bench for sweep_result_averager: randomized sweeps against a
// per-point running-sum model, read responses checked by a separate monitor.
module tb_sweep_result_averager;
    localparam int NP = 200;

    logic       clk125 = 1'b0;
    logic       areset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] avg_log2 = 3'd0;
    logic       busy, done, err_overrun, err_index;
    logic [7:0] sweep_count;

    sweep_result_averager_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    sweep_result_averager dut (
        .clk125      (clk125),
        .areset_n    (areset_n),
        .start       (start),
        .avg_log2    (avg_log2),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .sweep_count (sweep_count),
        .err_overrun (err_overrun),
        .err_index   (err_index)
    );

    always #4 clk125 = ~clk125;

    int     n_checks = 0;
    int     n_fail = 0;
    longint acc_m[NP], acc_p[NP];
    longint res_m[256], res_p[256];
    int     m_target, m_sweeps;
    longint exp_m_q[$], exp_p_q[$];

    task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact per-point sums, floor division by the sweep count.
    function automatic longint floor_div(longint a, longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_start(int lg);
        for (int i = 0; i < NP; i++) begin
            acc_m[i] = 0;
            acc_p[i] = 0;
        end
        m_target = 1 << lg;
        m_sweeps = 0;
    endtask

    task automatic model_sample(int idx, longint m, longint p);
        acc_m[idx] += m;
        acc_p[idx] += p;
        if (m_sweeps == m_target - 1) begin
            res_m[idx] = floor_div(acc_m[idx], m_target);
            res_p[idx] = floor_div(acc_p[idx], m_target);
        end
        if (idx == NP - 1) m_sweeps++;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk125);
        #1;
    endtask

    task automatic drive(int idx, logic signed [31:0] m, logic signed [31:0] p);
        bus.valid_m = 1'b1;
        bus.index   = idx[7:0];
        bus.modulo  = m;
        bus.phase   = p;
        tick(1);
        bus.valid_m = 1'b0;
    endtask

    task automatic send(int idx, logic signed [31:0] m, logic signed [31:0] p);
        drive(idx, m, p);
        model_sample(idx, m, p);
        tick(4);
    endtask

    task automatic push_expect(int addr);
        if (addr < NP) begin
            exp_m_q.push_back(res_m[addr]);
            exp_p_q.push_back(res_p[addr]);
        end else begin
            exp_m_q.push_back(0);
            exp_p_q.push_back(0);
        end
    endtask

    task automatic rd_check(int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr[7:0];
        push_expect(addr);
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic rd_random(int n);
        for (int k = 0; k < n; k++) rd_check(int'($urandom_range(0, 255)));
    endtask

    task automatic begin_job(int lg);
        avg_log2 = lg[2:0];
        start    = 1'b1;
        model_start(lg);
        tick(205);
    endtask

    task automatic random_sweep(int first, int last);
        for (int i = first; i <= last; i++) send(i, $urandom, $urandom);
    endtask

    always @(negedge clk125) begin : monitor
        longint em, ep;
        if (areset_n && bus.rd_valid === 1'b1) begin
            if (exp_m_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1, expected no read pending at %0t", $time);
            end else begin
                em = exp_m_q.pop_front();
                ep = exp_p_q.pop_front();
                check("rd_modulo", $signed(bus.rd_modulo), em);
                check("rd_phase", $signed(bus.rd_phase), ep);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int order[NP];
        int mv[4];
        int pv[4];
        logic signed [31:0] m, p;
        mv = '{100, 101, 102, 104};
        pv = '{-1, -1, -1, -2};
        bus.valid_m = 1'b0; bus.index = '0; bus.modulo = '0; bus.phase = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sweep_count", sweep_count, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_err_index", err_index, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_modulo", bus.rd_modulo, 0);
        check("rst_rd_phase", bus.rd_phase, 0);
        areset_n = 1'b1;
        tick(2);

        // Single sweep, modulo=i*10, phase=-i
        begin_job(0);
        for (int i = 0; i < NP - 1; i++) send(i, i * 10, -i);
        drive(NP - 1, (NP - 1) * 10, -(NP - 1));
        model_sample(NP - 1, (NP - 1) * 10, -(NP - 1));
        tick(1);
        check("A_done_early", done, 0);
        tick(1);
        check("A_done", done, 1);
        check("A_busy", busy, 0);
        check("A_sweep_count", sweep_count, 1);
        check("A_model_57", res_m[57], 570);
        rd_check(57); rd_check(0); rd_check(199); rd_check(200);
        start = 1'b0;
        tick(3);
        check("A_done_cleared", done, 0);

        // Four sweeps, shuffled index order, sweep boundary at the last index
        begin_job(2);
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NP; i++) order[i] = i;
            for (int i = NP - 2; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(0, i));
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            for (int i = 0; i < NP; i++) send(order[i], mv[s], pv[s]);
        end
        check("B_done", done, 1);
        check("B_sweep_count", sweep_count, 4);
        check("B_err_overrun", err_overrun, 0);
        check("B_err_index", err_index, 0);
        check("B_model_m", res_m[57], 101);
        check("B_model_p", res_p[57], -2);
        rd_check(57); rd_random(12); rd_check(255);
        start = 1'b0;
        tick(3);

        // Overrun during READ, read-first collision, out-of-range index in WAIT
        begin_job(0);
        for (int i = 0; i < NP; i++) begin
            m = $urandom; p = $urandom;
            if (i == 57) begin
                drive(57, m, p);
                bus.valid_m = 1'b1; bus.index = 8'd58; bus.modulo = ~m; bus.phase = ~p;
                tick(1);
                bus.valid_m = 1'b0;
                bus.rd_en = 1'b1; bus.rd_addr = 8'd57;
                push_expect(57);
                model_sample(57, m, p);
                tick(1);
                bus.rd_en = 1'b0;
                tick(3);
                check("C_err_overrun", err_overrun, 1);
            end else if (i == 120) begin
                drive(210, m, p);
                tick(2);
                check("C_err_index", err_index, 1);
                check("C_busy_in_wait", busy, 1);
                send(i, $urandom, $urandom);
            end else begin
                send(i, m, p);
            end
        end
        check("C_done", done, 1);
        check("C_err_overrun_sticky", err_overrun, 1);
        check("C_err_index_sticky", err_index, 1);
        rd_check(57); rd_check(58); rd_check(120); rd_random(10);
        start = 1'b0;
        tick(3);

        // Abort part-way through the final sweep of a two-sweep job
        begin_job(1);
        random_sweep(0, NP - 1);
        random_sweep(0, 99);
        start = 1'b0;
        tick(2);
        check("D_busy", busy, 0);
        check("D_done", done, 0);
        rd_check(0); rd_check(99); rd_check(100); rd_check(199); rd_random(10);
        tick(2);

        // Reset while a sample is in ACC, then restart with start held high
        begin_job(0);
        drive(5, 32'sd12345, -32'sd6789);
        tick(1);
        areset_n = 1'b0;
        #1;
        check("E_rst_busy", busy, 0);
        check("E_rst_done", done, 0);
        check("E_rst_sweep_count", sweep_count, 0);
        check("E_rst_rd_valid", bus.rd_valid, 0);
        check("E_rst_rd_modulo", bus.rd_modulo, 0);
        check("E_rst_rd_phase", bus.rd_phase, 0);
        tick(3);
        model_start(0);
        areset_n = 1'b1;
        tick(100);
        check("E_busy_clear", busy, 1);
        drive(3, 32'sd77, 32'sd77);
        tick(2);
        check("E_overrun_in_clear", err_overrun, 1);
        tick(110);
        random_sweep(0, NP - 1);
        check("E_done", done, 1);
        check("E_sweep_count", sweep_count, 1);
        rd_check(3); rd_check(5); rd_random(8);
        start = 1'b0;
        tick(5);
        check("rd_queue_empty", exp_m_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
